first_part: RTL and testbench



---
 rtl/first_part_pkg.sv | 58 +++++
 rtl/first_part_lut4.sv | 11 +
 rtl/first_part.sv | 125 ++++++++++++
 tb/tb_first_part.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/first_part_pkg.sv
// first_part_pkg: shared constants and LUT INIT-word generation for the
// LUT-based 8-bit squarer (first_part).
package first_part_pkg;

   localparam int DATA_W = 8;

   // Selector for the (a*b) mod 8 partial-product LUT functions.
   typedef enum logic [2:0] {
      PP_P0 = 3'd0,   // p[0] = a0&b0                        (in[1]=a0, in[0]=b0)
      PP_P1 = 3'd1,   // p[1] = a1&b0 ^ a0&b1                (in = {a1,a0,b1,b0})
      PP_T2 = 3'd2,   // t    = a1&b1 ^ (a1&b0 & a0&b1)      (in = {a1,a0,b1,b0})
      PP_U2 = 3'd3,   // u    = a2&b0 ^ a0&b2                (in = {a2,b0,a0,b2})
      PP_X2 = 3'd4    // p[2] = t ^ u                        (in[1]=t, in[0]=u)
   } pp_sel_e;

   // INIT word for bit bit_idx of b*b: entry k holds bit bit_idx of k*k.
   function automatic logic [15:0] sq_init(input int unsigned bit_idx);
      logic [15:0] w;
      logic [7:0]  sq;
      w = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         sq   = 8'(k * k);
         w[k] = sq[bit_idx[2:0]];
      end
      return w;
   endfunction

   // INIT word for one partial-product LUT; in[3:2] are don't-care for P0/X2.
   function automatic logic [15:0] pp_init(input pp_sel_e sel);
      logic [15:0] w;
      logic [3:0]  i;
      w = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         i = 4'(k);
         case (sel)
            PP_P0:   w[k] = i[1] & i[0];
            PP_P1:   w[k] = (i[3] & i[0]) ^ (i[2] & i[1]);
            PP_T2:   w[k] = (i[3] & i[1]) ^ (i[3] & i[0] & i[2] & i[1]);
            PP_U2:   w[k] = (i[3] & i[2]) ^ (i[1] & i[0]);
            PP_X2:   w[k] = i[1] ^ i[0];
            default: w[k] = 1'b0;
         endcase
      end
      return w;
   endfunction

   localparam logic [15:0] SQ_INIT [0:7] = '{
      sq_init(32'd0), sq_init(32'd1), sq_init(32'd2), sq_init(32'd3),
      sq_init(32'd4), sq_init(32'd5), sq_init(32'd6), sq_init(32'd7)
   };

   localparam logic [15:0] PP_P0_INIT = pp_init(PP_P0);
   localparam logic [15:0] PP_P1_INIT = pp_init(PP_P1);
   localparam logic [15:0] PP_T2_INIT = pp_init(PP_T2);
   localparam logic [15:0] PP_U2_INIT = pp_init(PP_U2);
   localparam logic [15:0] PP_X2_INIT = pp_init(PP_X2);

endpackage

// File: rtl/first_part_lut4.sv
// lut4: 4-input lookup-table primitive, o = INIT[in]. Purely combinational.
module lut4 #(
   parameter logic [15:0] INIT = 16'h0000
) (
   input  logic [3:0] in,
   output logic       o
);

   assign o = INIT[in];

endmodule

// File: rtl/first_part.sv
// first_part: registered LUT-based squarer, out = (inp*inp) mod 256.
// inp = 16*a + b;  (16a+b)^2 mod 256 = (b^2 + 32*((a*b) mod 8)) mod 256.
// Optional macro FIRST_PART_IN_REG_EN registers inp/inp_valid ahead of the
// LUT network (latency 2); without it the network is fed from the ports
// (latency 1). The arithmetic is identical in both builds.
module first_part #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] inp,
   input  logic              inp_valid,
   output logic [DATA_W-1:0] out,
   output logic              out_valid
);
   import first_part_pkg::*;

   if (DATA_W != 8) begin : g_bad_width
      $error("first_part: only DATA_W = 8 is supported");
   end

   logic [7:0] lut_inp_s;
   logic       lut_vld_s;
   logic [3:0] a_s;
   logic [3:0] b_s;
   logic [7:0] b_sq_s;
   logic [2:0] p_s;
   logic       t2_s;
   logic       u2_s;
   logic [7:0] sum_s;
   logic [7:0] out_d;
   logic [7:0] out_q;
   logic       valid_d;
   logic       valid_q;

`ifdef FIRST_PART_IN_REG_EN
   logic [7:0] inp_q;
   logic       in_valid_q;

   // Input stage: capture operand and qualifier; cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         inp_q      <= 8'h00;
         in_valid_q <= 1'b0;
      end else begin
         inp_q      <= inp;
         in_valid_q <= inp_valid;
      end
   end

   assign lut_inp_s = inp_q;
   assign lut_vld_s = in_valid_q;
`else
   assign lut_inp_s = inp;
   assign lut_vld_s = inp_valid;
`endif

   assign a_s = lut_inp_s[7:4];
   assign b_s = lut_inp_s[3:0];

   // b^2: one LUT per result bit, all addressed by the low nibble.
   for (genvar i = 0; i < 8; i++) begin : g_sq
      lut4 #(.INIT(SQ_INIT[i])) u_sq (
         .in (b_s),
         .o  (b_sq_s[i])
      );
   end

   // (a*b) mod 8 from a[2:0], b[2:0]. The P0 LUT's spare inputs carry a[3]
   // and b[3]; its INIT ignores them, so the function is unaffected.
   lut4 #(.INIT(PP_P0_INIT)) u_pp_p0 (
      .in ({a_s[3], b_s[3], a_s[0], b_s[0]}),
      .o  (p_s[0])
   );

   lut4 #(.INIT(PP_P1_INIT)) u_pp_p1 (
      .in ({a_s[1], a_s[0], b_s[1], b_s[0]}),
      .o  (p_s[1])
   );

   // Bit 2 needs six inputs plus the bit-1 carry: split across three LUTs.
   lut4 #(.INIT(PP_T2_INIT)) u_pp_t2 (
      .in ({a_s[1], a_s[0], b_s[1], b_s[0]}),
      .o  (t2_s)
   );

   lut4 #(.INIT(PP_U2_INIT)) u_pp_u2 (
      .in ({a_s[2], b_s[0], a_s[0], b_s[2]}),
      .o  (u2_s)
   );

   lut4 #(.INIT(PP_X2_INIT)) u_pp_x2 (
      .in ({1'b0, 1'b0, t2_s, u2_s}),
      .o  (p_s[2])
   );

   // 8-bit wrap-around add; carries above bit 7 are dropped.
   assign sum_s = b_sq_s + {p_s, 5'b00000};

   // Next-state: load a new result only when qualified, otherwise hold.
   always_comb begin
      out_d   = out_q;
      valid_d = lut_vld_s;
      if (lut_vld_s) begin
         out_d = sum_s;
      end else begin
         out_d = out_q;
      end
   end

   // Output register; reset has priority over a valid operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_first_part.sv
// tb_first_part: directed self-checking bench for first_part.
module tb_first_part;

`ifdef FIRST_PART_IN_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] inp;
   logic       inp_valid;
   logic [7:0] out;
   logic       out_valid;

   int tests;
   int fails;

   // reference model state
   logic       s_v;
   logic [7:0] s_d;
   logic       m_v;
   logic [7:0] m_out;
   logic [7:0] hand_q[$];
   int         n_valid;

   first_part #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .inp       (inp),
      .inp_valid (inp_valid),
      .out       (out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] sq8(input logic [7:0] d);
      logic [15:0] p;
      p = 16'(d) * 16'(d);
      return p[7:0];
   endfunction

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, compare outputs.
   task automatic step(input logic r, input logic v, input logic [7:0] d);
      rst       = r;
      inp_valid = v;
      inp       = d;
      @(posedge clk);
      #1;
      if (r) begin
         s_v   = 1'b0;
         s_d   = 8'h00;
         m_v   = 1'b0;
         m_out = 8'h00;
      end else if (LAT == 2) begin
         m_v = s_v;
         if (s_v) m_out = sq8(s_d);
         s_v = v;
         s_d = d;
      end else begin
         m_v = v;
         if (v) m_out = sq8(d);
      end
      check1("out_valid", out_valid, m_v);
      check8("out", out, m_out);
      if (out_valid) n_valid++;
      if (m_v && hand_q.size() > 0) check8("hand_vector", out, hand_q.pop_front());
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      n_valid   = 0;
      s_v       = 1'b0;
      s_d       = 8'h00;
      m_v       = 1'b0;
      m_out     = 8'h00;
      rst       = 1'b1;
      inp       = 8'h00;
      inp_valid = 1'b0;

      // reset held two cycles, with a valid operand present (reset wins)
      step(1'b1, 1'b1, 8'h5A);
      step(1'b1, 1'b1, 8'h5A);
      check8("reset_out", out, 8'h00);
      check1("reset_valid", out_valid, 1'b0);

      // hand-computed stream, back-to-back
      hand_q = '{8'hE1, 8'h69, 8'h09, 8'h01};
      step(1'b0, 1'b1, 8'h0F);
      step(1'b0, 1'b1, 8'h13);
      step(1'b0, 1'b1, 8'h83);
      step(1'b0, 1'b1, 8'hFF);
      for (int k = 0; k < LAT; k++) step(1'b0, 1'b0, 8'hA5);
      check32("stream_drained", hand_q.size(), 0);

      // idle with changing operand: out holds, valid low
      step(1'b0, 1'b0, 8'h37);
      check8("hold_out", out, 8'h01);
      check1("hold_valid", out_valid, 1'b0);

      // wrap boundaries
      hand_q = '{8'h00, 8'h00, 8'h00, 8'h01};
      step(1'b0, 1'b1, 8'h10);
      step(1'b0, 1'b1, 8'h80);
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'hFF);
      for (int k = 0; k < LAT; k++) step(1'b0, 1'b0, 8'h00);
      check32("boundary_drained", hand_q.size(), 0);

      // exhaustive sweep; count valid beats for no-bubble alignment
      n_valid = 0;
      for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 8'(i));
      for (int k = 0; k < LAT; k++) step(1'b0, 1'b0, 8'h00);
      check32("sweep_valid_count", n_valid, 256);
      check8("sweep_last", out, 8'h01);

      // reset mid-stream discards in-flight results
      step(1'b0, 1'b1, 8'h21);
      step(1'b0, 1'b1, 8'h35);
      step(1'b1, 1'b1, 8'h44);
      check8("midrst_out", out, 8'h00);
      check1("midrst_valid", out_valid, 1'b0);

      // resume: first valid follows normal latency (7*7 = 49 = 0x31)
      hand_q = '{8'h31, 8'hC4};
      step(1'b0, 1'b1, 8'h07);
      step(1'b0, 1'b1, 8'h0E);
      for (int k = 0; k < LAT; k++) step(1'b0, 1'b0, 8'h00);
      check32("resume_drained", hand_q.size(), 0);
      check8("resume_last", out, 8'hC4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
